data_mem_responder: RTL

Byte-addressed data memory responder serving the pipeline's MEM-stage load/store port with a configurable number of wait states. It accepts one request at a time from the EX/MEM register outputs and stalls the pipeline with `busy` until the access completes. It formats loads and merges stores per `funct3`, which lets the pipeline move off the single-cycle memory model onto a realistic-latency one.

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder: WAIT_CYCLES wait states, then one response cycle; busy stalls the pipe.
// Optional misaligned-access trap selected by `DM_MISALIGN_TRAP_EN` (otherwise addresses are force-aligned).
module data_mem_responder #(
   parameter int DATA_W      = 32,
   parameter int DM_ADDRESS  = 9,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            funct3,
   output logic                  busy,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  err
);

   localparam int WORDS = 2 ** (DM_ADDRESS - 2);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [DM_ADDRESS-1:0] addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic [2:0]            f3_q, f3_d;
   logic                  we_q, we_d;

   logic                  req, legal;
   logic [DM_ADDRESS-1:0] addr_al;
   logic [DATA_W-1:0]     mem [WORDS];
   logic [DATA_W-1:0]     word, wword, fmt;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [3:0]            be;

   always_comb begin
      req = mem_read | mem_write;
      case (funct3)
         3'b000, 3'b001, 3'b010: legal = 1'b1;
         3'b100, 3'b101:         legal = ~mem_write;
         default:                legal = 1'b0;
      endcase
      legal   = legal & ~(mem_read & mem_write);
      addr_al = addr;
`ifdef DM_MISALIGN_TRAP_EN
      if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
         legal = 1'b0;
`else
      if (funct3[1:0] == 2'b01) addr_al[0] = 1'b0;
      if (funct3[1:0] == 2'b10) addr_al[1:0] = 2'b00;
`endif
   end

   // Load formatting and store lane selection both work off the captured request.
   always_comb begin
      word   = mem[addr_q[DM_ADDRESS-1:2]];
      byte_v = word[8*addr_q[1:0] +: 8];
      half_v = addr_q[1] ? word[31:16] : word[15:0];
      case (f3_q)
         3'b000:  fmt = {{(DATA_W-8){byte_v[7]}}, byte_v};
         3'b001:  fmt = {{(DATA_W-16){half_v[15]}}, half_v};
         3'b100:  fmt = {{(DATA_W-8){1'b0}}, byte_v};
         3'b101:  fmt = {{(DATA_W-16){1'b0}}, half_v};
         default: fmt = word;
      endcase
      case (f3_q[1:0])
         2'b00: begin be = 4'b0001 << addr_q[1:0]; wword = {4{wdata_q[7:0]}}; end
         2'b01: begin be = addr_q[1] ? 4'b1100 : 4'b0011; wword = {2{wdata_q[15:0]}}; end
         default: begin be = 4'b1111; wword = wdata_q; end
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      f3_d     = f3_q;
      we_d     = we_q;
      busy     = 1'b0;
      rd_valid = 1'b0;
      rd_data  = '0;
      err      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req && legal) begin
               busy    = 1'b1;
               addr_d  = addr_al;
               wdata_d = wr_data;
               f3_d    = funct3;
               we_d    = mem_write;
               cnt_d   = CNT_LOAD;
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end else if (req) begin
               err = 1'b1;
            end
         end
         S_WAIT: begin
            busy = 1'b1;
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP: begin
            rd_valid = ~we_q;
            rd_data  = we_q ? '0 : fmt;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      // Held reset must silence the combinational IDLE outputs too.
      if (!reset) begin
         busy     = 1'b0;
         rd_valid = 1'b0;
         rd_data  = '0;
         err      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         f3_q    <= 3'b000;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         f3_q    <= f3_d;
         we_q    <= we_d;
      end
   end

   // Array is not reset; an async reset already forces state out of RESP, dropping a pending store.
   always_ff @(posedge clk) begin
      if (state_q == S_RESP && we_q) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[addr_q[DM_ADDRESS-1:2]][8*i +: 8] <= wword[8*i +: 8];
      end
   end

endmodule
